// File: rtl/fp16_add_arbiter_if.sv
// Request, adder and response channels between the FP16 adder arbiter and its neighbours.
// slave is the arbiter's view; master is the requesters/adder/consumer side.
interface fp16_add_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic                  add_start;
    logic [15:0]           add_a;
    logic [15:0]           add_b;
    logic [15:0]           add_sum;
    logic                  add_n;
    logic                  add_v;
    logic                  add_z;
    logic                  add_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [15:0]           rsp_sum;
    logic [2:0]            rsp_flags;

    modport slave (
        input  req_valid, req_a, req_b, add_sum, add_n, add_v, add_z, add_ready, rsp_ready,
        output req_ready, add_start, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_flags
    );

    modport master (
        output req_valid, req_a, req_b, add_sum, add_n, add_v, add_z, add_ready, rsp_ready,
        input  req_ready, add_start, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_flags
    );
endinterface

// File: rtl/fp16_add_arbiter.sv
// Round-robin sequencer sharing one sequential FP16 adder among NUM_REQ requesters,
// with a WAIT timeout and a drain period after reset or timeout.
module fp16_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int TIMEOUT = 16,
    parameter int DRAIN   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    fp16_add_arbiter_if.slave bus,
    output logic              busy,
    output logic              timeout_err
);
    typedef enum logic [2:0] {S_DRAIN, S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    localparam int CNT_MAX = (TIMEOUT > DRAIN) ? TIMEOUT : DRAIN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [15:0]      QNAN     = 16'h7E00;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [15:0]        add_a_q, add_a_d, add_b_q, add_b_d;
    logic [15:0]        rsp_sum_q, rsp_sum_d;
    logic [2:0]         rsp_flags_q, rsp_flags_d;
    logic               add_start_q, add_start_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;
    logic               tmo_err_q, tmo_err_d;
    logic               drain_arm_q, drain_arm_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    win_id;
    logic               win_found;
    logic [15:0]        sel_a, sel_b;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant     = '0;
        cand      = '0;
        win_id    = '0;
        win_found = 1'b0;
        sel_a     = '0;
        sel_b     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_id_q) + k) % NUM_REQ);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
        if (state_q == S_IDLE && win_found) grant[win_id] = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = bus.req_a[16*i +: 16];
                sel_b = bus.req_b[16*i +: 16];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_id_d   = last_id_q;
        rsp_id_d    = rsp_id_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_flags_d = rsp_flags_q;
        tmo_err_d   = tmo_err_q;
        drain_arm_d = drain_arm_q;
        unique case (state_q)
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_IDLE: begin
                if (win_found) begin
                    add_a_d   = sel_a;
                    add_b_d   = sel_b;
                    rsp_id_d  = win_id;
                    last_id_d = win_id;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.add_ready) begin
                    rsp_sum_d   = bus.add_sum;
                    rsp_flags_d = {bus.add_n, bus.add_v, bus.add_z};
                    state_d     = S_RESP;
                end else if (cnt_q == TMO_LAST) begin
                    rsp_sum_d   = QNAN;
                    rsp_flags_d = 3'b010;
                    tmo_err_d   = 1'b1;
                    drain_arm_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    if (drain_arm_q) begin
                        drain_arm_d = 1'b0;
                        cnt_d       = DRAIN_LD;
                        state_d     = S_DRAIN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_DRAIN;
        endcase
        add_start_d = (state_d == S_ISSUE);
        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_DRAIN;
            cnt_q       <= DRAIN_LD;
            last_id_q   <= ID_W'(NUM_REQ - 1);
            rsp_id_q    <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_sum_q   <= '0;
            rsp_flags_q <= '0;
            add_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            tmo_err_q   <= 1'b0;
            drain_arm_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_id_q   <= last_id_d;
            rsp_id_q    <= rsp_id_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_flags_q <= rsp_flags_d;
            add_start_q <= add_start_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            tmo_err_q   <= tmo_err_d;
            drain_arm_q <= drain_arm_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.add_start = add_start_q;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign busy          = busy_q;
    assign timeout_err   = tmo_err_q;
endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Directed bench for fp16_add_arbiter: a 3-cycle adder model, grant order, backpressure,
// timeout with drain, reset mid-operation and stray adder-ready pulses.
module tb_fp16_add_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic busy, timeout_err;
    logic model_rdy = 1'b0;
    logic stray_rdy = 1'b0;
    logic model_en  = 1'b1;
    logic [15:0] model_sum = '0;
    logic [2:0]  model_flags = '0;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fp16_add_arbiter_if #(.NUM_REQ(4)) bus ();

    fp16_add_arbiter #(.NUM_REQ(4), .TIMEOUT(16), .DRAIN(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    assign bus.add_ready = model_rdy | stray_rdy;
    assign bus.add_sum   = model_sum;
    assign bus.add_n     = model_flags[2];
    assign bus.add_v     = model_flags[1];
    assign bus.add_z     = model_flags[0];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Adder answers three cycles after it sees start (ready in cycle 4 of an operation).
    initial begin : adder_model
        int dly;
        dly = 0;
        forever begin
            @(posedge clk);
            #1;
            model_rdy = 1'b0;
            if (bus.add_start) dly = 3;
            else if (dly > 0) begin
                dly--;
                if (dly == 0 && model_en) model_rdy = 1'b1;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_add_start", 32'(bus.add_start), 0);
        chk("rst_add_ab", {bus.add_a, bus.add_b}, 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_fields", {11'd0, bus.rsp_id, bus.rsp_sum, bus.rsp_flags}, 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("drain_req_ready", 32'(bus.req_ready), 0);
            chk("drain_rsp_valid", 32'(bus.rsp_valid), 0);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_reached", 32'(busy), 0);
    endtask

    initial begin : stim
        int ng, last_c;
        bus.req_valid = '0;
        bus.req_a     = {16'h1003, 16'h1002, 16'h1001, 16'h3C00};
        bus.req_b     = {16'h2003, 16'hC000, 16'h2001, 16'h3C00};
        bus.rsp_ready = 1'b1;
        bus.req_a[47:32] = 16'h4000;
        @(negedge clk);
        do_reset();

        // Stray adder-ready while idle
        @(negedge clk);
        stray_rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stray_idle_rsp", 32'(bus.rsp_valid), 0);
            chk("stray_idle_busy", 32'(busy), 0);
        end
        stray_rdy = 1'b0;

        // Single request, requester 0: 1.0 + 1.0
        model_sum = 16'h4000; model_flags = 3'b000;
        @(negedge clk);
        bus.req_valid = 4'b0001;
        #1 chk("single_grant", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        chk("single_start", 32'(bus.add_start), 1);
        chk("single_ab", {bus.add_a, bus.add_b}, 32'h3C003C00);
        bus.req_valid = 4'b0000;
        @(negedge clk);
        chk("single_start_pulse", 32'(bus.add_start), 0);
        repeat (2) @(negedge clk);
        chk("single_no_rsp_c4", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        chk("single_rsp", {bus.rsp_valid, 9'd0, bus.rsp_id, bus.rsp_sum, bus.rsp_flags},
            {1'b1, 9'd0, 2'd0, 16'h4000, 3'b000});
        @(negedge clk);
        chk("single_back_idle", {31'd0, busy}, 0);

        // Fairness: all four valid from reset
        model_sum = 16'h4200;
        bus.req_valid = 4'b1111;
        do_reset();
        ng = 0; last_c = 0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                chk("fair_onehot", 32'($onehot(bus.req_ready)), 1);
                chk("fair_order", 32'(bus.req_ready), 32'(1 << (ng % 4)));
                if (ng > 0) chk("fair_spacing", c - last_c, 6);
                last_c = c;
                ng++;
            end
        end
        chk("fair_grants", ng, 6);
        @(negedge clk);
        bus.req_valid = '0;
        wait_idle();

        // Backpressure: requester 2 (2.0 + -2.0), requester 3 waiting
        model_sum = 16'h0000; model_flags = 3'b001;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 4'b1100;
        #1 chk("bp_grant", 32'(bus.req_ready), 32'h4);
        @(negedge clk);
        bus.req_valid = 4'b1000;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_flags, bus.req_ready},
                {1'b1, 2'd2, 16'h0000, 3'b001, 4'b0000});
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_next_grant", 32'(bus.req_ready), 32'h8);
        chk("bp_rsp_done", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        bus.req_valid = '0;
        wait_idle();

        // Timeout: adder never answers, requester 1
        model_en = 1'b0;
        @(negedge clk);
        bus.req_valid = 4'b0010;
        #1 chk("tmo_grant", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        chk("tmo_start", 32'(bus.add_start), 1);
        bus.req_valid = '0;
        repeat (16) @(negedge clk);
        chk("tmo_not_yet", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        chk("tmo_rsp", {bus.rsp_valid, 9'd0, bus.rsp_id, bus.rsp_sum, bus.rsp_flags},
            {1'b1, 9'd0, 2'd1, 16'h7E00, 3'b010});
        chk("tmo_err_set", 32'(timeout_err), 1);
        bus.req_valid = 4'b0001;
        stray_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("tmo_drain_ready", 32'(bus.req_ready), 0);
            chk("tmo_drain_rsp", 32'(bus.rsp_valid), 0);
        end
        stray_rdy = 1'b0;
        model_en = 1'b1;
        @(negedge clk);
        chk("tmo_post_grant", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = '0;
        wait_idle();
        chk("tmo_err_sticky", 32'(timeout_err), 1);

        // Reset in cycle 3 of an operation for requester 2
        @(negedge clk);
        bus.req_valid = 4'b0100;
        #1 chk("rw_grant", 32'(bus.req_ready), 32'h4);
        @(negedge clk);
        bus.req_valid = 4'b0101;
        repeat (2) @(negedge clk);
        do_reset();
        @(negedge clk);
        chk("rw_first_grant", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = '0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fp16_add_arbiter.md
# fp16_add_arbiter

Round-robin arbiter and sequencer that shares one sequential half-precision adder among `NUM_REQ` requesters, such as the accumulators of the sparse-matrix multiply datapath. It accepts one operand pair at a time over a valid/ready handshake and pulses the adder's `start`. It then waits for the adder's `ready`, checking against a timeout, and returns the sum, flags and requester ID over a valid/ready response channel. Only one operation is outstanding at a time.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, $clog2(NUM_REQ): width of the requester ID.
- `TIMEOUT`, 16: maximum number of WAIT cycles before the operation is aborted. Must be ≥ 4.
- `DRAIN`, 4: number of cycles the block holds off after reset or after a timeout.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_a`  in  16*NUM_REQ  left operand; requester i at [16i+15:16i].
- `req_b`  in  16*NUM_REQ  right operand, packed the same way.
- `req_ready`  out  NUM_REQ  one-hot accept; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `add_start`  out  1  one-cycle start pulse to the adder.
- `add_a`, `add_b`  out  16  adder operands, held stable from ISSUE through WAIT.
- `add_sum`  in  16  adder result.
- `add_n`, `add_v`, `add_z`  in  1  adder flags.
- `add_ready`  in  1  adder done.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  ID_W  requester index of the response.
- `rsp_sum`  out  16  result.
- `rsp_flags`  out  3  {n,v,z}.
- `busy`  out  1  high in any state other than IDLE.
- `timeout_err`  out  1  sticky; set on timeout, cleared only by reset.

## Operation
- FSM states: DRAINING, IDLE, ISSUE, WAIT, RESP. Reset enters DRAINING.
- DRAINING
  - Down-counter loaded with DRAIN-1; go to IDLE when it reaches 0.
  - `add_ready` is ignored.
  - Purpose: lets an adder with no reset finish any in-flight operation.
- IDLE
  - If any `req_valid` is high, select winner w by round-robin.
  - Priority starts at `last_id+1` and wraps modulo NUM_REQ.
  - `req_ready[w]=1`, combinational in the same cycle; all other `req_ready` bits are 0.
  - Latch operands w into `add_a`/`add_b`, set `rsp_id<=w` and `last_id<=w`, go to ISSUE.
  - `req_ready` is 0 in every state other than IDLE.
- ISSUE
  - `add_start=1` for exactly this cycle.
  - Clear the WAIT counter and go to WAIT.
- WAIT
  - If `add_ready` is high, capture `add_sum` and {n,v,z} into the `rsp_*` registers and go to RESP.
  - Otherwise increment the counter.
  - If the counter reaches TIMEOUT-1 with no `add_ready`:
    - `rsp_sum<=16'h7E00` (qNaN), `rsp_flags<=3'b010`, `timeout_err<=1`.
    - Go to RESP, and arm the post-timeout drain.
- RESP
  - `rsp_valid=1`; `rsp_id`, `rsp_sum` and `rsp_flags` stay stable until `rsp_ready`.
  - On the handshake, go to IDLE, or to DRAINING if the post-timeout drain is armed.
- `last_id` resets to NUM_REQ-1, so requester 0 wins first after reset.
- Operands are passed to the adder unmodified; this block performs no arithmetic.

## Timing
- Reset values:
  - `req_ready=0`, `add_start=0`, `add_a=add_b=0`.
  - `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `rsp_flags=0`.
  - `busy=1` (DRAINING), `timeout_err=0`.
- Cycle numbering, with cycle 0 as the request handshake in IDLE:
  - `add_start` is asserted in cycle 1.
  - With the nominal adder, `add_ready` is high in cycle 4.
  - `rsp_valid` first goes high in cycle 5.
- If `rsp_ready` is already high in cycle 5, the block is back in IDLE in cycle 6. Peak throughput is one operation per 6 cycles.
- A `req_valid` that rises in the same cycle as the RESP handshake is not granted until the next cycle (IDLE).
- If two or more requesters are valid simultaneously, exactly one is granted; the others wait with no loss of request.
- A requester may deassert `req_valid` before it is granted without side effects.
- `add_ready` is ignored outside WAIT.
- Asynchronous reset mid-operation: all outputs take their reset values immediately; the pending request and response are discarded and are not replayed.

## Test plan
- Single request: `req_valid=4'b0001`, A=16'h3C00, B=16'h3C00; adder model returns 16'h4000.
  - Required: grant in cycle 0, `add_start` in cycle 1, `rsp_valid` in cycle 5 with `rsp_id=0`, `rsp_sum=16'h4000`, `rsp_flags=3'b000`.
- Fairness: all four requesters valid continuously.
  - Required: grant order 0,1,2,3,0,1; each `req_ready` is one-hot; 6 cycles between grants when `rsp_ready=1`.
- Backpressure: hold `rsp_ready=0` for 10 cycles after `rsp_valid`.
  - Required: response fields stay stable, `req_ready` stays 0, and the next grant comes in the cycle after the handshake.
- Timeout: adder model never asserts `add_ready`.
  - Required: `rsp_valid` with `rsp_sum=16'h7E00` and `rsp_flags=3'b010`, `timeout_err=1` thereafter.
  - Required: after the response handshake, 4 DRAINING cycles before the next grant.
- Reset mid-WAIT: assert `rst_n=0` in cycle 3.
  - Required: outputs take reset values immediately; no `rsp_valid`; no grant for 4 cycles after release; first grant goes to requester 0.
- Stray ready: pulse `add_ready` while in IDLE and in DRAINING.
  - Required: no response and no state change.
